// File: rtl/axonerve_kvs_axi_slave_mem.sv
// ---------------------------------------------------------------------------
// axonerve_kvs_axi_slave_mem
//
// AXI4 memory responder that stands in for global memory. It lets the kernel's
// read/write masters and the KVS user logic run in block simulation or on-chip
// loopback without a DDR controller. It handles the AW/W/B/AR/R subset with
// INCR bursts, no IDs and no response codes. There is one outstanding write
// burst and one outstanding read burst, and the two channels run independently.
//
// Addressing: word index = addr[log2(DW/8) +: log2(C_MEM_DEPTH_WORDS)].
// Byte-offset bits and upper address bits are ignored. The index wraps modulo
// the memory depth.
//
// Optional feature (compile-time macro):
//   AXONERVE_KVS_SLAVE_MEM_STRB_EN  defined   -> s_axi_wstrb byte enables honoured
//                                   undefined -> every beat writes the full word
//
// Ports:
//   aclk, aresetn                 clock, asynchronous active-low reset
//   s_axi_aw{valid,ready,addr,len}  write address channel
//   s_axi_w{valid,ready,data,strb,last}  write data channel
//   s_axi_b{valid,ready}          write completion
//   s_axi_ar{valid,ready,addr,len}  read address channel
//   s_axi_r{valid,ready,data,last}  read data channel
//   protocol_err                  sticky: wlast disagreed with the awlen count
// ---------------------------------------------------------------------------
module axonerve_kvs_axi_slave_mem #(
  parameter int C_S_AXI_ADDR_WIDTH = 64,
  parameter int C_S_AXI_DATA_WIDTH = 512,
  parameter int C_MEM_DEPTH_WORDS  = 1024
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  input  logic                              s_axi_awvalid,
  output logic                              s_axi_awready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic [7:0]                        s_axi_awlen,
  input  logic                              s_axi_wvalid,
  output logic                              s_axi_wready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                              s_axi_wlast,
  output logic                              s_axi_bvalid,
  input  logic                              s_axi_bready,
  input  logic                              s_axi_arvalid,
  output logic                              s_axi_arready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic [7:0]                        s_axi_arlen,
  output logic                              s_axi_rvalid,
  input  logic                              s_axi_rready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_rdata,
  output logic                              s_axi_rlast,
  output logic                              protocol_err
);

  localparam int BYTE_BITS = $clog2(C_S_AXI_DATA_WIDTH / 8);
  localparam int IDX_BITS  = $clog2(C_MEM_DEPTH_WORDS);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  logic [C_S_AXI_DATA_WIDTH-1:0] mem [0:C_MEM_DEPTH_WORDS-1];

  w_state_t w_state, w_state_next;
  r_state_t r_state, r_state_next;

  logic [IDX_BITS-1:0] w_idx;
  logic [7:0]          w_len;
  logic [7:0]          w_cnt;
  logic                w_final;

  logic [IDX_BITS-1:0] r_idx;
  logic [8:0]          r_left;
  logic                rd_issue;

  // Stage 1 holds the word just read from memory. Stage 2 is the R output
  // register. Together they form a two-entry skid.
  logic                          s1_valid;
  logic                          s1_last;
  logic [C_S_AXI_DATA_WIDTH-1:0] s1_data;
  logic                          s1_free;
  logic                          s2_load;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

  // Address bits outside the word index are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{s_axi_awaddr, s_axi_araddr, s_axi_wstrb};

  assign aw_hs = s_axi_awvalid & s_axi_awready;
  assign w_hs  = s_axi_wvalid  & s_axi_wready;
  assign b_hs  = s_axi_bvalid  & s_axi_bready;
  assign ar_hs = s_axi_arvalid & s_axi_arready;
  assign r_hs  = s_axi_rvalid  & s_axi_rready;

  assign w_final = (w_cnt == w_len);

  // ------------------------------------------------------------ write FSM
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) w_state <= W_IDLE;
    else          w_state <= w_state_next;
  end

  always_comb begin
    w_state_next = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs)           w_state_next = W_DATA;
      W_DATA:  if (w_hs && w_final) w_state_next = W_RESP;
      W_RESP:  if (b_hs)            w_state_next = W_IDLE;
      default:                      w_state_next = W_IDLE;
    endcase
  end

  // Ready/valid are registered from the next state, so they change on the
  // same edge as the handshake that moves the FSM.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
    end else begin
      s_axi_awready <= (w_state_next == W_IDLE);
      s_axi_wready  <= (w_state_next == W_DATA);
      s_axi_bvalid  <= (w_state_next == W_RESP);
    end
  end

  // The burst length always follows awlen. A mismatching wlast only raises
  // the sticky error flag; it never shortens or extends the burst.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_idx        <= '0;
      w_len        <= '0;
      w_cnt        <= '0;
      protocol_err <= 1'b0;
    end else begin
      if (aw_hs) begin
        w_idx <= s_axi_awaddr[BYTE_BITS +: IDX_BITS];
        w_len <= s_axi_awlen;
        w_cnt <= '0;
      end else if (w_hs) begin
        w_idx <= w_idx + 1'b1;
        w_cnt <= w_cnt + 8'd1;
        if (s_axi_wlast != w_final) protocol_err <= 1'b1;
      end
    end
  end

  // Memory array has no reset, so its contents survive aresetn.
`ifdef AXONERVE_KVS_SLAVE_MEM_STRB_EN
  always_ff @(posedge aclk) begin
    if (w_hs) begin
      for (int b = 0; b < C_S_AXI_DATA_WIDTH / 8; b++) begin
        if (s_axi_wstrb[b]) mem[w_idx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      end
    end
  end
`else
  always_ff @(posedge aclk) begin
    if (w_hs) mem[w_idx] <= s_axi_wdata;
  end
`endif

  // ------------------------------------------------------------- read FSM
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= R_IDLE;
    else          r_state <= r_state_next;
  end

  always_comb begin
    r_state_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs)               r_state_next = R_DATA;
      R_DATA:  if (r_hs && s_axi_rlast) r_state_next = R_IDLE;
      default:                          r_state_next = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) s_axi_arready <= 1'b0;
    else          s_axi_arready <= (r_state_next == R_IDLE);
  end

  // Stage 2 loads whenever it is empty or being drained. A memory read is
  // issued whenever stage 1 will have room after this edge.
  assign s2_load  = s1_valid & (~s_axi_rvalid | s_axi_rready);
  assign s1_free  = ~s1_valid | s2_load;
  assign rd_issue = (r_state == R_DATA) & (r_left != 9'd0) & s1_free;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_idx  <= '0;
      r_left <= '0;
    end else if (ar_hs) begin
      r_idx  <= s_axi_araddr[BYTE_BITS +: IDX_BITS];
      r_left <= {1'b0, s_axi_arlen} + 9'd1;
    end else if (rd_issue) begin
      r_idx  <= r_idx + 1'b1;
      r_left <= r_left - 9'd1;
    end
  end

  // Nonblocking read of the array gives read-first behaviour when the same
  // word is written on the same edge.
  always_ff @(posedge aclk) begin
    if (rd_issue) s1_data <= mem[r_idx];
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
    end else if (rd_issue) begin
      s1_valid <= 1'b1;
      s1_last  <= (r_left == 9'd1);
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  // Output register: rdata/rlast only change on a load, so they hold during
  // backpressure.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= '0;
      s_axi_rlast  <= 1'b0;
    end else if (s2_load) begin
      s_axi_rvalid <= 1'b1;
      s_axi_rdata  <= s1_data;
      s_axi_rlast  <= s1_last;
    end else if (r_hs) begin
      s_axi_rvalid <= 1'b0;
      s_axi_rlast  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axonerve_kvs_axi_slave_mem.sv
// ---------------------------------------------------------------------------
// tb_axonerve_kvs_axi_slave_mem
//
// Self-checking bench for axonerve_kvs_axi_slave_mem with default parameters
// (64-bit address, 512-bit data, 1024 words). A word-array reference model is
// updated from the addressing rules (byte address / 64, modulo depth). Every
// read beat is compared against that model.
// ---------------------------------------------------------------------------
module tb_axonerve_kvs_axi_slave_mem;

  localparam int AW    = 64;
  localparam int DW    = 512;
  localparam int SW    = DW / 8;
  localparam int DEPTH = 1024;

  logic            aclk = 1'b0;
  logic            aresetn;
  logic            s_axi_awvalid, s_axi_awready;
  logic [AW-1:0]   s_axi_awaddr;
  logic [7:0]      s_axi_awlen;
  logic            s_axi_wvalid, s_axi_wready;
  logic [DW-1:0]   s_axi_wdata;
  logic [SW-1:0]   s_axi_wstrb;
  logic            s_axi_wlast;
  logic            s_axi_bvalid, s_axi_bready;
  logic            s_axi_arvalid, s_axi_arready;
  logic [AW-1:0]   s_axi_araddr;
  logic [7:0]      s_axi_arlen;
  logic            s_axi_rvalid, s_axi_rready;
  logic [DW-1:0]   s_axi_rdata;
  logic            s_axi_rlast;
  logic            protocol_err;

  always #5 aclk = ~aclk;

  axonerve_kvs_axi_slave_mem dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awlen   (s_axi_awlen),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wlast   (s_axi_wlast),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arlen   (s_axi_arlen),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rlast   (s_axi_rlast),
    .protocol_err  (protocol_err)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] model_mem [0:DEPTH-1];
  logic [DW-1:0] wbuf [0:255];
  logic [SW-1:0] sbuf [0:255];

  // Word reached by beat 'beat' of a burst starting at byte address 'addr'.
  function automatic int word_of(input logic [AW-1:0] addr, input int beat);
    logic [AW-1:0] w;
    w = addr / 64'(SW) + 64'(beat);
    return int'(w % 64'(DEPTH));
  endfunction

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  function automatic void model_write(input int idx, input logic [DW-1:0] d,
                                      input logic [SW-1:0] s);
`ifdef AXONERVE_KVS_SLAVE_MEM_STRB_EN
    for (int b = 0; b < SW; b++) if (s[b]) model_mem[idx][b*8 +: 8] = d[b*8 +: 8];
`else
    if (s !== s) model_mem[idx] = 'x;
    model_mem[idx] = d;
`endif
  endfunction

  // Write burst of len+1 beats from wbuf/sbuf. bad_last marks an extra beat
  // carrying wlast=1. gaps inserts random idle cycles on W.
  task automatic do_write(input logic [AW-1:0] addr, input int len,
                          input int bad_last, input bit gaps);
    int n;
    s_axi_awaddr  = addr;
    s_axi_awlen   = 8'(len);
    s_axi_awvalid = 1'b1;
    n = 0;
    @(negedge aclk);
    while (!s_axi_awready && n < 100) begin @(negedge aclk); n++; end
    if (!s_axi_awready) begin
      errors++; $display("[TB] FAIL aw_timeout awready=%0b required 1", s_axi_awready);
    end
    @(posedge aclk); #1;
    s_axi_awvalid = 1'b0;
    checks++;
    if (s_axi_awready !== 1'b0 || s_axi_wready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL aw_accept awready=%0b wready=%0b required 0 1",
               s_axi_awready, s_axi_wready);
    end
    for (int b = 0; b <= len; b++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_axi_wvalid = 1'b0;
        @(posedge aclk); #1;
      end
      s_axi_wdata  = wbuf[b];
      s_axi_wstrb  = sbuf[b];
      s_axi_wlast  = (b == len) || (b == bad_last);
      s_axi_wvalid = 1'b1;
      n = 0;
      @(negedge aclk);
      while (!s_axi_wready && n < 100) begin @(negedge aclk); n++; end
      if (!s_axi_wready) begin
        errors++; $display("[TB] FAIL w_timeout beat=%0d wready=%0b required 1", b, s_axi_wready);
      end
      @(posedge aclk); #1;
      model_write(word_of(addr, b), wbuf[b], sbuf[b]);
      checks++;
      if (b == len) begin
        if (s_axi_wready !== 1'b0 || s_axi_bvalid !== 1'b1) begin
          errors++;
          $display("[TB] FAIL w_final wready=%0b bvalid=%0b required 0 1",
                   s_axi_wready, s_axi_bvalid);
        end
      end else if (s_axi_wready !== 1'b1 || s_axi_bvalid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL w_mid beat=%0d wready=%0b bvalid=%0b required 1 0",
                 b, s_axi_wready, s_axi_bvalid);
      end
    end
    s_axi_wvalid = 1'b0;
    s_axi_wlast  = 1'b0;
    // Hold off bready one cycle: bvalid must persist.
    @(posedge aclk); #1;
    checks++;
    if (s_axi_bvalid !== 1'b1) begin
      errors++; $display("[TB] FAIL b_hold bvalid=%0b required 1", s_axi_bvalid);
    end
    s_axi_bready = 1'b1;
    @(posedge aclk); #1;
    s_axi_bready = 1'b0;
    checks++;
    if (s_axi_bvalid !== 1'b0 || s_axi_awready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b_done bvalid=%0b awready=%0b required 0 1",
               s_axi_bvalid, s_axi_awready);
    end
  endtask

  // Read burst and compare with the model. mode 0: rready always 1 (no
  // bubbles allowed), 1: rready pattern 1,0,0 repeating, 2: random.
  // abort_at >= 0 pulls aresetn low once that many beats have been accepted.
  task automatic do_read(input logic [AW-1:0] addr, input int len,
                         input int mode, input int abort_at);
    int n, beat, cyc;
    bit stalled, rr;
    logic [DW-1:0] held_d, exp_d;
    logic held_l;
    s_axi_araddr  = addr;
    s_axi_arlen   = 8'(len);
    s_axi_arvalid = 1'b1;
    n = 0;
    @(negedge aclk);
    while (!s_axi_arready && n < 100) begin @(negedge aclk); n++; end
    if (!s_axi_arready) begin
      errors++; $display("[TB] FAIL ar_timeout arready=%0b required 1", s_axi_arready);
    end
    @(posedge aclk); #1;
    s_axi_arvalid = 1'b0;
    checks++;
    if (s_axi_arready !== 1'b0 || s_axi_rvalid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ar_accept arready=%0b rvalid=%0b required 0 0",
               s_axi_arready, s_axi_rvalid);
    end
    @(posedge aclk); #1;
    checks++;
    if (s_axi_rvalid !== 1'b0) begin
      errors++; $display("[TB] FAIL first_rvalid_t1 rvalid=%0b required 0", s_axi_rvalid);
    end
    @(posedge aclk); #1;
    checks++;
    if (s_axi_rvalid !== 1'b1) begin
      errors++; $display("[TB] FAIL first_rvalid_t2 rvalid=%0b required 1", s_axi_rvalid);
    end
    beat = 0; cyc = 0; stalled = 1'b0; held_d = '0; held_l = 1'b0;
    while (beat <= len && cyc < 300) begin
      if (beat == abort_at) begin
        s_axi_rready = 1'b0;
        #2 aresetn = 1'b0;
        #1;
        checks++;
        if (s_axi_rvalid !== 1'b0 || s_axi_rlast !== 1'b0 || s_axi_rdata !== '0 ||
            s_axi_arready !== 1'b0 || s_axi_awready !== 1'b0) begin
          errors++;
          $display("[TB] FAIL reset_mid_read rvalid=%0b rlast=%0b arready=%0b awready=%0b required all 0",
                   s_axi_rvalid, s_axi_rlast, s_axi_arready, s_axi_awready);
        end
        return;
      end
      case (mode)
        0:       rr = 1'b1;
        1:       rr = (cyc % 3 == 0);
        default: rr = 1'($urandom_range(0, 1));
      endcase
      s_axi_rready = rr;
      @(negedge aclk);
      if (stalled) begin
        checks++;
        if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== held_d || s_axi_rlast !== held_l) begin
          errors++;
          $display("[TB] FAIL r_hold beat=%0d rvalid=%0b rlast=%0b got %h required %h",
                   beat, s_axi_rvalid, s_axi_rlast, s_axi_rdata, held_d);
        end
      end
      if (mode == 0) begin
        checks++;
        if (s_axi_rvalid !== 1'b1) begin
          errors++; $display("[TB] FAIL r_bubble beat=%0d rvalid=%0b required 1", beat, s_axi_rvalid);
        end
      end
      if (s_axi_rvalid === 1'b1 && rr) begin
        exp_d = model_mem[word_of(addr, beat)];
        checks++;
        if (s_axi_rdata !== exp_d) begin
          errors++;
          $display("[TB] FAIL r_data beat=%0d got %h required %h", beat, s_axi_rdata, exp_d);
        end
        checks++;
        if (s_axi_rlast !== (beat == len)) begin
          errors++;
          $display("[TB] FAIL r_last beat=%0d got %0b required %0b", beat, s_axi_rlast, beat == len);
        end
        beat++;
        stalled = 1'b0;
      end else begin
        stalled = (s_axi_rvalid === 1'b1);
        held_d  = s_axi_rdata;
        held_l  = s_axi_rlast;
      end
      @(posedge aclk); #1;
      cyc++;
    end
    s_axi_rready = 1'b0;
    if (beat <= len) begin
      errors++; $display("[TB] FAIL r_timeout beats=%0d required %0d", beat, len + 1);
    end
    checks++;
    if (s_axi_rvalid !== 1'b0 || s_axi_arready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL r_done rvalid=%0b arready=%0b required 0 1", s_axi_rvalid, s_axi_arready);
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    s_axi_awvalid = 0; s_axi_awaddr = '0; s_axi_awlen = '0;
    s_axi_wvalid = 0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 0;
    s_axi_bready = 0; s_axi_arvalid = 0; s_axi_araddr = '0; s_axi_arlen = '0;
    s_axi_rready = 0;
    repeat (3) @(negedge aclk);
    checks++;
    if ({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid,
         s_axi_rlast, protocol_err} !== 7'b0 || s_axi_rdata !== '0) begin
      errors++;
      $display("[TB] FAIL reset_values aw=%0b w=%0b b=%0b ar=%0b r=%0b last=%0b err=%0b required all 0",
               s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready,
               s_axi_rvalid, s_axi_rlast, protocol_err);
    end
    aresetn = 1'b1;
    @(posedge aclk); #1;
    checks++;
    if (s_axi_awready !== 1'b1 || s_axi_arready !== 1'b1 || s_axi_wready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_release awready=%0b arready=%0b wready=%0b required 1 1 0",
               s_axi_awready, s_axi_arready, s_axi_wready);
    end
  endtask

  task automatic test_basic_burst();
    for (int i = 0; i < 4; i++) begin
      wbuf[i] = DW'(8'hA0 + i);
      sbuf[i] = '1;
    end
    do_write(64'h40, 3, -1, 1'b0);
    do_read(64'h40, 3, 0, -1);
    checks++;
    if (protocol_err !== 1'b0) begin
      errors++; $display("[TB] FAIL basic_protocol_err got %0b required 0", protocol_err);
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 8; i++) begin wbuf[i] = rand_word(); sbuf[i] = '1; end
    do_write(64'h800, 7, -1, 1'b1);
    do_read(64'h800, 7, 1, -1);
  endtask

  task automatic test_strobe();
    wbuf[0] = '1; sbuf[0] = '1;
    do_write(64'h280, 0, -1, 1'b0);
    wbuf[0] = '0; sbuf[0] = SW'(64'h0F);
    do_write(64'h280, 0, -1, 1'b0);
    do_read(64'h280, 0, 0, -1);
  endtask

  task automatic test_wrap();
    wbuf[0] = rand_word(); wbuf[1] = rand_word();
    sbuf[0] = '1; sbuf[1] = '1;
    do_write(64'((DEPTH - 1) * SW), 1, -1, 1'b0);
    do_read(64'h0, 0, 0, -1);
    do_read(64'((DEPTH - 1) * SW), 1, 2, -1);
  endtask

  task automatic test_wlast_error();
    for (int i = 0; i < 3; i++) begin wbuf[i] = rand_word(); sbuf[i] = '1; end
    do_write(64'h1000, 2, 1, 1'b0);
    checks++;
    if (protocol_err !== 1'b1) begin
      errors++; $display("[TB] FAIL wlast_err got %0b required 1", protocol_err);
    end
    do_read(64'h1000, 2, 0, -1);
    wbuf[0] = rand_word(); sbuf[0] = '1;
    do_write(64'h1100, 0, -1, 1'b0);
    checks++;
    if (protocol_err !== 1'b1) begin
      errors++; $display("[TB] FAIL wlast_sticky got %0b required 1", protocol_err);
    end
  endtask

  task automatic test_reset_mid_read();
    for (int i = 0; i < 8; i++) begin wbuf[i] = rand_word(); sbuf[i] = '1; end
    do_write(64'h2000, 7, -1, 1'b0);
    do_read(64'h2000, 7, 0, 2);
    repeat (2) @(negedge aclk);
    checks++;
    if (protocol_err !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_clears_err got %0b required 0", protocol_err);
    end
    aresetn = 1'b1;
    @(posedge aclk); #1;
    do_read(64'h2000, 7, 0, -1);
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    int len;
    for (int it = 0; it < 6; it++) begin
      len = $urandom_range(0, 15);
      a = {32'($urandom), 32'($urandom)};
      for (int i = 0; i <= len; i++) begin
        wbuf[i] = rand_word();
`ifdef AXONERVE_KVS_SLAVE_MEM_STRB_EN
        sbuf[i] = '1;
`else
        sbuf[i] = {32'($urandom), 32'($urandom)};
`endif
      end
      do_write(a, len, -1, 1'b1);
      // Different byte offset and upper bits must address the same words.
      a[5:0] = 6'($urandom);
      a[AW-1:20] = 44'($urandom);
      do_read(a, len, 2, -1);
    end
  endtask

  initial begin
    test_reset();
    test_basic_burst();
    test_backpressure();
    test_strobe();
    test_wrap();
    test_wlast_error();
    test_reset_mid_read();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
